// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcodes, FSM states
// and the opcode legality helper.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] OP_MUL = 3'd2;
  localparam logic [ALU_OP_W-1:0] OP_AND = 3'd3;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic op_is_valid(input logic [ALU_OP_W-1:0] op);
    return (op <= OP_OR);
  endfunction

endpackage

// File: rtl/alu_rr_scheduler_alu.sv
// Shared combinational ALU. Unknown opcodes produce zero; the scheduler
// masks the result for those anyway.
module alu_rr_scheduler_alu
  import alu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0]       i_data0,
  input  logic [DW-1:0]       i_data1,
  input  logic [ALU_OP_W-1:0] i_alu_ctrl,
  output logic [DW-1:0]       o_data,
  output logic                o_zero
);

  always_comb begin
    o_data = '0;
    case (i_alu_ctrl)
      OP_ADD:  o_data = i_data0 + i_data1;
      OP_SUB:  o_data = i_data0 - i_data1;
      OP_MUL:  o_data = i_data0 * i_data1;
      OP_AND:  o_data = i_data0 & i_data1;
      OP_OR:   o_data = i_data0 | i_data1;
      default: o_data = '0;
    endcase
  end

  assign o_zero = (o_data == '0);

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin sharing of one ALU between two requesters: accept one op,
// execute for a fixed window (longer for MUL), then hold the response.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DW      = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                req0_valid_i,
  output logic                req0_ready_o,
  input  logic [ALU_OP_W-1:0] req0_op_i,
  input  logic [DW-1:0]       req0_a_i,
  input  logic [DW-1:0]       req0_b_i,
  input  logic                req1_valid_i,
  output logic                req1_ready_o,
  input  logic [ALU_OP_W-1:0] req1_op_i,
  input  logic [DW-1:0]       req1_a_i,
  input  logic [DW-1:0]       req1_b_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_id_o,
  output logic [DW-1:0]       rsp_data_o,
  output logic                rsp_zero_o,
  output logic                rsp_err_o,
  output logic                busy_o
);

  localparam logic [3:0] CNT_MUL = 4'(MUL_LAT - 1);

  state_t              r_state;
  logic                r_rr;
  logic [3:0]          r_cnt;
  logic [ALU_OP_W-1:0] r_op;
  logic [DW-1:0]       r_a;
  logic [DW-1:0]       r_b;
  logic                r_id;
  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic [DW-1:0]       r_rsp_data;
  logic                r_rsp_zero;
  logic                r_rsp_err;

  logic                w_accept;
  logic                w_gnt_id;
  logic [ALU_OP_W-1:0] w_sel_op;
  logic [DW-1:0]       w_sel_a;
  logic [DW-1:0]       w_sel_b;
  logic [DW-1:0]       w_alu_data;
  logic                w_alu_zero;
  logic                w_op_ok;

  // r_rr remembers who was served last; on a tie the other side wins.
  assign w_gnt_id = (req0_valid_i && req1_valid_i) ? ~r_rr : req1_valid_i;
  assign w_accept = (r_state == IDLE) && (req0_valid_i || req1_valid_i);

  assign req0_ready_o = w_accept && !w_gnt_id;
  assign req1_ready_o = w_accept &&  w_gnt_id;

  assign w_sel_op = w_gnt_id ? req1_op_i : req0_op_i;
  assign w_sel_a  = w_gnt_id ? req1_a_i  : req0_a_i;
  assign w_sel_b  = w_gnt_id ? req1_b_i  : req0_b_i;

  alu_rr_scheduler_alu #(.DW(DW)) u_alu (
    .i_data0    (r_a),
    .i_data1    (r_b),
    .i_alu_ctrl (r_op),
    .o_data     (w_alu_data),
    .o_zero     (w_alu_zero)
  );

  assign w_op_ok = op_is_valid(r_op);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_rr        <= 1'b1;
      r_cnt       <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= w_sel_op;
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_id    <= w_gnt_id;
            r_rr    <= w_gnt_id;
            r_cnt   <= (w_sel_op == OP_MUL) ? CNT_MUL : 4'd0;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_err   <= !w_op_ok;
            r_rsp_data  <= w_op_ok ? w_alu_data : '0;
            r_rsp_zero  <= w_op_ok && w_alu_zero;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_id_o    = r_rsp_id;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_zero_o  = r_rsp_zero;
  assign rsp_err_o   = r_rsp_err;
  assign busy_o      = (r_state != IDLE);

endmodule
